// File: rtl/game_round_sequencer.sv
// Round sequencer for the shooting game: spawns and launches sprites, paces
// sprite motion off the video frame, tracks shots/hits/score/level and hands
// the end-of-round display time to the end-of-game timer.
module game_round_sequencer #(
  parameter int unsigned SHOTS_PER_ROUND = 8,
  parameter int unsigned HITS_TO_WIN     = 3,
  parameter int unsigned SHOT_WIDTH      = 4,
  parameter int unsigned SCORE_WIDTH     = 8,
  parameter int unsigned LEVEL_WIDTH     = 2,
  parameter int unsigned DIV_BASE        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   key,
  input  logic                   collision,
  input  logic                   target_within_screen,
  input  logic                   torpedo_within_screen,
  input  logic                   end_of_game_timer_running,
  output logic                   target_write_xy,
  output logic                   target_write_dxy,
  output logic                   torpedo_write_xy,
  output logic                   torpedo_write_dxy,
  output logic                   target_enable_update,
  output logic                   torpedo_enable_update,
  output logic                   end_of_game_timer_start,
  output logic                   game_won,
  output logic                   game_lost,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [SHOT_WIDTH-1:0]  shots_left,
  output logic [LEVEL_WIDTH-1:0] level
);

  localparam int unsigned DIV_WIDTH = (DIV_BASE > 2) ? $clog2(DIV_BASE) : 1;
  localparam logic [SHOT_WIDTH-1:0] SHOTS_INIT = SHOT_WIDTH'(SHOTS_PER_ROUND);
  localparam logic [SHOT_WIDTH-1:0] HITS_WIN   = SHOT_WIDTH'(HITS_TO_WIN);

  typedef enum logic [2:0] {
    IDLE, SPAWN, AIM, FLIGHT, HIT, MISS, WON, LOST
  } state_t;

  state_t state, state_next;

  logic                  key_q;
  logic [DIV_WIDTH-1:0]  div;
  logic [SHOT_WIDTH-1:0] hits;
  logic                  seen_run;

  logic key_rise, step;
  logic [SHOT_WIDTH-1:0] hits_inc;

  logic txy_d, tdxy_d, pxy_d, pdxy_d, ten_d, pen_d, tstart_d, won_d, lost_d;
  logic shot_take, hit_take, leave_won, leave_lost;

  assign key_rise = key & ~key_q;
  assign step     = frame_tick & (div == '0);
  assign hits_inc = hits + SHOT_WIDTH'(1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and strobe decode; strobes are registered below
  always_comb begin
    state_next = state;
    txy_d      = 1'b0;
    tdxy_d     = 1'b0;
    pxy_d      = 1'b0;
    pdxy_d     = 1'b0;
    ten_d      = 1'b0;
    pen_d      = 1'b0;
    tstart_d   = 1'b0;
    shot_take  = 1'b0;
    hit_take   = 1'b0;
    leave_won  = 1'b0;
    leave_lost = 1'b0;
    case (state)
      IDLE: if (key_rise) state_next = SPAWN;
      SPAWN: begin
        txy_d      = 1'b1;
        tdxy_d     = 1'b1;
        pxy_d      = 1'b1;
        state_next = AIM;
      end
      AIM: begin
        ten_d = step;
        if (key_rise && shots_left != '0) begin
          pdxy_d     = 1'b1;
          shot_take  = 1'b1;
          state_next = FLIGHT;
        end else if (frame_tick && !target_within_screen) begin
          state_next = SPAWN;
        end
      end
      FLIGHT: begin
        ten_d = step;
        pen_d = step;
        if (collision) begin
          state_next = HIT;
        end else if (frame_tick && !torpedo_within_screen) begin
          state_next = MISS;
        end else if (frame_tick && !target_within_screen) begin
          txy_d  = 1'b1;
          tdxy_d = 1'b1;
        end
      end
      HIT: begin
        hit_take = 1'b1;
        if (hits_inc == HITS_WIN) begin
          tstart_d   = 1'b1;
          state_next = WON;
        end else if (shots_left == '0) begin
          tstart_d   = 1'b1;
          state_next = LOST;
        end else begin
          state_next = SPAWN;
        end
      end
      MISS: begin
        if (shots_left == '0) begin
          tstart_d   = 1'b1;
          state_next = LOST;
        end else begin
          pxy_d      = 1'b1;
          state_next = AIM;
        end
      end
      WON: if (seen_run && !end_of_game_timer_running) begin
        leave_won  = 1'b1;
        state_next = IDLE;
      end
      LOST: if (seen_run && !end_of_game_timer_running) begin
        leave_lost = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Flags follow the next state so they line up with the WON/LOST dwell
    won_d  = (state_next == WON);
    lost_d = (state_next == LOST);
  end

  // Registered strobes, enables and end-of-round flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_write_xy         <= 1'b0;
      target_write_dxy        <= 1'b0;
      torpedo_write_xy        <= 1'b0;
      torpedo_write_dxy       <= 1'b0;
      target_enable_update    <= 1'b0;
      torpedo_enable_update   <= 1'b0;
      end_of_game_timer_start <= 1'b0;
      game_won                <= 1'b0;
      game_lost               <= 1'b0;
    end else begin
      target_write_xy         <= txy_d;
      target_write_dxy        <= tdxy_d;
      torpedo_write_xy        <= pxy_d;
      torpedo_write_dxy       <= pdxy_d;
      target_enable_update    <= ten_d;
      torpedo_enable_update   <= pen_d;
      end_of_game_timer_start <= tstart_d;
      game_won                <= won_d;
      game_lost               <= lost_d;
    end
  end

  // Key edge history, frame divider and round/score bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q      <= 1'b0;
      div        <= '0;
      hits       <= '0;
      seen_run   <= 1'b0;
      score      <= '0;
      level      <= '0;
      shots_left <= SHOTS_INIT;
    end else begin
      key_q <= key;
      if (frame_tick) begin
        if (div == '0) div <= DIV_WIDTH'(DIV_BASE - 1) - DIV_WIDTH'(level);
        else           div <= div - DIV_WIDTH'(1);
      end
      if (shot_take) shots_left <= shots_left - SHOT_WIDTH'(1);
      if (hit_take) begin
        if (hits != '1)  hits  <= hits_inc;
        if (score != '1) score <= score + SCORE_WIDTH'(1);
      end
      if ((state == WON || state == LOST) && end_of_game_timer_running)
        seen_run <= 1'b1;
      if (leave_won || leave_lost) begin
        seen_run   <= 1'b0;
        hits       <= '0;
        shots_left <= SHOTS_INIT;
      end
      if (leave_won && level != '1) level <= level + LEVEL_WIDTH'(1);
      if (leave_lost) begin
        score <= '0;
        level <= '0;
      end
    end
  end

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed bench for game_round_sequencer: a per-cycle vector table for the
// win path and sprite events, then hand sequences for the loss path, frame
// pacing and asynchronous reset.
module tb_game_round_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic frame_tick, key, collision, target_within_screen, torpedo_within_screen;
  logic end_of_game_timer_running;
  logic target_write_xy, target_write_dxy, torpedo_write_xy, torpedo_write_dxy;
  logic target_enable_update, torpedo_enable_update, end_of_game_timer_start;
  logic game_won, game_lost;
  logic [7:0] score;
  logic [3:0] shots_left;
  logic [1:0] level;

  game_round_sequencer #(
    .SHOTS_PER_ROUND(8),
    .HITS_TO_WIN(3),
    .SHOT_WIDTH(4),
    .SCORE_WIDTH(8),
    .LEVEL_WIDTH(2),
    .DIV_BASE(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .key(key),
    .collision(collision),
    .target_within_screen(target_within_screen),
    .torpedo_within_screen(torpedo_within_screen),
    .end_of_game_timer_running(end_of_game_timer_running),
    .target_write_xy(target_write_xy),
    .target_write_dxy(target_write_dxy),
    .torpedo_write_xy(torpedo_write_xy),
    .torpedo_write_dxy(torpedo_write_dxy),
    .target_enable_update(target_enable_update),
    .torpedo_enable_update(torpedo_enable_update),
    .end_of_game_timer_start(end_of_game_timer_start),
    .game_won(game_won),
    .game_lost(game_lost),
    .score(score),
    .shots_left(shots_left),
    .level(level)
  );

  always #5 clk = ~clk;

  // Strobe vector order: {txy, tdxy, pxy, pdxy, ten, pen, tstart, won, lost}
  localparam logic [8:0] S_NONE   = 9'b000000000;
  localparam logic [8:0] S_SPAWN  = 9'b111000000;
  localparam logic [8:0] S_TRESP  = 9'b110000000;
  localparam logic [8:0] S_TORP   = 9'b001000000;
  localparam logic [8:0] S_LAUNCH = 9'b000100000;
  localparam logic [8:0] S_EN     = 9'b000011000;
  localparam logic [8:0] S_TSTART = 9'b000000100;
  localparam logic [8:0] S_WON    = 9'b000000010;
  localparam logic [8:0] S_LOST   = 9'b000000001;

  typedef struct {
    logic       key, ft, col, tws, torws, run;
    logic [8:0] strb;
    logic [7:0] score;
    logic [3:0] shots;
    logic [1:0] lvl;
  } vec_t;

  vec_t vq[$];
  int n_vec = 0;
  int n_miss = 0;

  function automatic vec_t mk(input logic k, input logic ft, input logic col,
                              input logic tws, input logic torws, input logic run,
                              input logic [8:0] strb, input int sc,
                              input int sh, input int lv);
    vec_t v;
    v.key = k; v.ft = ft; v.col = col; v.tws = tws; v.torws = torws; v.run = run;
    v.strb = strb; v.score = 8'(sc); v.shots = 4'(sh); v.lvl = 2'(lv);
    return v;
  endfunction

  function automatic logic [8:0] strobes();
    return {target_write_xy, target_write_dxy, torpedo_write_xy, torpedo_write_dxy,
            target_enable_update, torpedo_enable_update, end_of_game_timer_start,
            game_won, game_lost};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic k, input logic ft, input logic col,
                       input logic tws, input logic torws, input logic run);
    key = k; frame_tick = ft; collision = col;
    target_within_screen = tws; torpedo_within_screen = torws;
    end_of_game_timer_running = run;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int tcount, pcount;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 1, 1, 0);

    // Win path, respawn and in-flight target rewrite, one row per cycle
    vq.push_back(mk(0,0,0,1,1,0, S_NONE,   0,8,0)); // 0 idle
    vq.push_back(mk(1,0,0,1,1,0, S_NONE,   0,8,0)); // 1 key rise -> SPAWN
    vq.push_back(mk(1,0,0,1,1,0, S_SPAWN,  0,8,0)); // 2 spawn pulses
    vq.push_back(mk(1,0,0,1,1,0, S_NONE,   0,8,0)); // 3 held key: no launch
    vq.push_back(mk(0,0,0,1,1,0, S_NONE,   0,8,0)); // 4
    vq.push_back(mk(1,0,0,1,1,0, S_LAUNCH, 0,7,0)); // 5 launch
    vq.push_back(mk(0,0,0,1,1,0, S_NONE,   0,7,0)); // 6
    vq.push_back(mk(1,0,0,1,1,0, S_NONE,   0,7,0)); // 7 key in FLIGHT ignored
    vq.push_back(mk(0,0,1,1,1,0, S_NONE,   0,7,0)); // 8 collision -> HIT
    vq.push_back(mk(0,0,0,1,1,0, S_NONE,   1,7,0)); // 9 HIT -> SPAWN
    vq.push_back(mk(0,0,0,1,1,0, S_SPAWN,  1,7,0)); // 10
    vq.push_back(mk(1,0,0,1,1,0, S_LAUNCH, 1,6,0)); // 11 launch
    vq.push_back(mk(0,1,1,1,0,0, S_EN,     1,6,0)); // 12 collision beats miss; div=0 step
    vq.push_back(mk(0,0,0,1,1,0, S_NONE,   2,6,0)); // 13 HIT -> SPAWN
    vq.push_back(mk(0,0,0,1,1,0, S_SPAWN,  2,6,0)); // 14
    vq.push_back(mk(1,0,0,1,1,0, S_LAUNCH, 2,5,0)); // 15 launch
    vq.push_back(mk(0,0,1,1,1,0, S_NONE,   2,5,0)); // 16 collision
    vq.push_back(mk(0,0,0,1,1,0, S_TSTART|S_WON, 3,5,0)); // 17 third hit
    vq.push_back(mk(0,0,0,1,1,1, S_WON,    3,5,0)); // 18 timer running
    vq.push_back(mk(0,0,0,1,1,1, S_WON,    3,5,0)); // 19
    vq.push_back(mk(0,0,0,1,1,0, S_NONE,   3,8,1)); // 20 timer fell -> IDLE
    vq.push_back(mk(0,0,0,1,1,0, S_NONE,   3,8,1)); // 21
    vq.push_back(mk(1,0,0,1,1,0, S_NONE,   3,8,1)); // 22 key rise
    vq.push_back(mk(0,0,0,1,1,0, S_SPAWN,  3,8,1)); // 23
    vq.push_back(mk(0,1,0,0,1,0, S_NONE,   3,8,1)); // 24 target off in AIM: respawn
    vq.push_back(mk(0,0,0,1,1,0, S_SPAWN,  3,8,1)); // 25 no shot used
    vq.push_back(mk(1,0,0,1,1,0, S_LAUNCH, 3,7,1)); // 26 launch
    vq.push_back(mk(0,1,0,0,1,0, S_TRESP,  3,7,1)); // 27 target off in FLIGHT
    vq.push_back(mk(0,1,0,1,1,0, S_NONE,   3,7,1)); // 28 div 1->0
    vq.push_back(mk(0,1,0,1,1,0, S_EN,     3,7,1)); // 29 step (level 1 period 3)
    vq.push_back(mk(0,1,0,1,0,0, S_NONE,   3,7,1)); // 30 torpedo off -> MISS
    vq.push_back(mk(0,0,0,1,1,0, S_TORP,   3,7,1)); // 31 MISS -> AIM
    vq.push_back(mk(0,0,0,1,1,0, S_NONE,   3,7,1)); // 32

    // Reset values while reset is held
    step();
    step();
    check("reset strobes", int'(strobes()), int'(S_NONE));
    check("reset score", int'(score), 0);
    check("reset shots", int'(shots_left), 8);
    check("reset level", int'(level), 0);
    #3 reset = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].key, vq[i].ft, vq[i].col, vq[i].tws, vq[i].torws, vq[i].run);
      step();
      check($sformatf("vec%0d strobes", i), int'(strobes()), int'(vq[i].strb));
      check($sformatf("vec%0d score", i), int'(score), int'(vq[i].score));
      check($sformatf("vec%0d shots", i), int'(shots_left), int'(vq[i].shots));
      check($sformatf("vec%0d level", i), int'(level), int'(vq[i].lvl));
    end

    // Remaining 7 shots all miss: last MISS starts the timer and loses
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 1, 1, 0);
      step();
      check($sformatf("loss%0d launch", i), int'(torpedo_write_dxy), 1);
      check($sformatf("loss%0d shots", i), int'(shots_left), 6 - i);
      drive(0, 1, 0, 1, 0, 0);
      step();
      drive(0, 0, 0, 1, 1, 0);
      step();
      check($sformatf("loss%0d torp rewrite", i), int'(torpedo_write_xy), (i < 6) ? 1 : 0);
      check($sformatf("loss%0d timer start", i), int'(end_of_game_timer_start), (i == 6) ? 1 : 0);
      check($sformatf("loss%0d lost", i), int'(game_lost), (i == 6) ? 1 : 0);
    end
    drive(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("lost hold%0d", i), int'(strobes()), int'(S_LOST));
    end
    drive(0, 0, 0, 1, 1, 0);
    step();
    check("after loss strobes", int'(strobes()), int'(S_NONE));
    check("after loss score", int'(score), 0);
    check("after loss level", int'(level), 0);
    check("after loss shots", int'(shots_left), 8);

    // Level 0 pacing: 12 frame ticks in AIM give 3 target steps, no torpedo steps
    drive(1, 0, 0, 1, 1, 0);
    step();
    drive(0, 0, 0, 1, 1, 0);
    step();
    check("pace spawn", int'(strobes()), int'(S_SPAWN));
    tcount = 0;
    pcount = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 0, 1, 1, 0);
      step();
      tcount += int'(target_enable_update);
      pcount += int'(torpedo_enable_update);
      drive(0, 0, 0, 1, 1, 0);
      step();
      tcount += int'(target_enable_update);
      pcount += int'(torpedo_enable_update);
    end
    check("pace target steps", tcount, 3);
    check("pace torpedo steps", pcount, 0);
    check("pace shots", int'(shots_left), 8);

    // Asynchronous reset in FLIGHT clears outputs before the next edge
    drive(1, 0, 0, 1, 1, 0);
    step();
    check("flight launch", int'(torpedo_write_dxy), 1);
    check("flight shots", int'(shots_left), 7);
    #2 reset = 1'b0;
    #1;
    check("async strobes", int'(strobes()), int'(S_NONE));
    check("async shots", int'(shots_left), 8);
    check("async score", int'(score), 0);
    drive(0, 0, 0, 1, 1, 0);
    step();
    #2 reset = 1'b1;
    step();
    check("post reset idle", int'(strobes()), int'(S_NONE));
    drive(1, 0, 0, 1, 1, 0);
    step();
    drive(0, 0, 0, 1, 1, 0);
    step();
    check("post reset spawn", int'(strobes()), int'(S_SPAWN));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
